// File: rtl/zsy_pkg.sv
// rtl/zsy_pkg.sv - shared types and constants for the key-entry block
//
// Purpose:
//   Holds the operand-select FSM encoding, the operand width, the wrap
//   limits for the decimal and hex builds, the per-cycle press-event
//   bundle and the operand increment helper.
//
// Ports: none (package).
// Configuration macro used by importers: ZSY_HEX_EN (hex operands 0..15).

package zsy_pkg;

  // Operand width and the largest value an operand may hold per build.
  localparam int OPW = 4;
  localparam logic [OPW-1:0] DEC_MAX = 4'd9;
  localparam logic [OPW-1:0] HEX_MAX = 4'd15;

  typedef logic [OPW-1:0] operand_t;

  // Which operand the INC key currently targets.
  typedef enum logic {
    S_A = 1'b0,
    S_B = 1'b1
  } state_t;

  // One-cycle press events from the three debouncers.
  typedef struct packed {
    logic inc;
    logic sel;
    logic clr;
  } press_t;

  // Increment with wrap to zero once the build's limit has been reached.
  // Using >= keeps the digit legal even if it were ever above the limit.
  function automatic operand_t wrap_inc(input operand_t value, input operand_t limit);
    if (value >= limit) begin
      return '0;
    end
    return value + operand_t'(1);
  endfunction

endpackage

// File: rtl/zsy_debounce.sv
// rtl/zsy_debounce.sv - key synchronizer, debouncer and press-pulse generator
//
// Purpose:
//   Brings one raw asynchronous button into the clock domain through a
//   two-flop synchronizer, filters it with a stability counter and emits a
//   single-cycle registered pulse on each debounced rising edge.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   key    in   raw active-high button
//   press  out  one-cycle pulse per debounced press (registered)
//
// Parameters:
//   DEB_CYCLES  consecutive stable synchronized cycles required (2..65535)

module zsy_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  // The counter reaches DEB_CYCLES-1 on the last differing cycle, at which
  // point the level flips; 16 bits cover the largest legal setting.
  localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic        level_d;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= key;
      sync2   <= sync1;
      level_d <= level;
      // Rising edge of the debounced level only; release is silent and a
      // held key cannot retrigger because level stays high.
      press   <= level & ~level_d;

      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        // Any return to the current level is a bounce: start over.
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/zsy_key_entry.sv
// rtl/zsy_key_entry.sv - three-button operand entry (A/B digits, select, clear)
//
// Purpose:
//   Debounces the INC, SEL and CLR buttons and maintains two operand
//   digits plus an operand-select FSM. INC bumps the selected digit with
//   wrap, SEL toggles the selection, CLR zeroes everything. UPD pulses for
//   one cycle after every applied press.
//
// Ports:
//   CP       in   system clock, rising edge
//   MR       in   asynchronous active-low reset
//   KEY_INC  in   raw increment button
//   KEY_SEL  in   raw operand-select button
//   KEY_CLR  in   raw clear button
//   A        out  operand A (registered)
//   B        out  operand B (registered)
//   SEL      out  selected operand, 0 = A, 1 = B (registered)
//   UPD      out  one-cycle pulse the cycle after A/B/SEL change (registered)
//
// Parameters:
//   DEB_CYCLES  debounce stability length in cycles (2..65535)
//
// Configuration macro:
//   ZSY_HEX_EN  defined: operands count 0..15; undefined: 0..9 (BCD)

module zsy_key_entry
  import zsy_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic           CP,
  input  logic           MR,
  input  logic           KEY_INC,
  input  logic           KEY_SEL,
  input  logic           KEY_CLR,
  output logic [OPW-1:0] A,
  output logic [OPW-1:0] B,
  output logic           SEL,
  output logic           UPD
);

`ifdef ZSY_HEX_EN
  localparam operand_t OP_LIMIT = HEX_MAX;
`else
  localparam operand_t OP_LIMIT = DEC_MAX;
`endif

  logic     inc_press;
  logic     sel_press;
  logic     clr_press;
  press_t   ev;

  state_t   state;
  state_t   state_nx;
  operand_t a_q;
  operand_t a_nx;
  operand_t b_q;
  operand_t b_nx;
  logic     pend_q;
  logic     pend_nx;
  logic     upd_q;

  zsy_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (CP),
    .rst_n (MR),
    .key   (KEY_INC),
    .press (inc_press)
  );

  zsy_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk   (CP),
    .rst_n (MR),
    .key   (KEY_SEL),
    .press (sel_press)
  );

  zsy_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (CP),
    .rst_n (MR),
    .key   (KEY_CLR),
    .press (clr_press)
  );

  assign ev = '{inc: inc_press, sel: sel_press, clr: clr_press};

  // FSM state register.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state <= S_A;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, next operands and the "something was applied" flag.
  // CLR wins outright. INC and SEL together: INC uses the current
  // selection, so the pre-toggle operand is the one that moves.
  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    b_nx     = b_q;
    pend_nx  = 1'b0;

    if (ev.clr) begin
      state_nx = S_A;
      a_nx     = '0;
      b_nx     = '0;
      pend_nx  = 1'b1;
    end else begin
      if (ev.inc) begin
        if (state == S_A) begin
          a_nx = wrap_inc(a_q, OP_LIMIT);
        end else begin
          b_nx = wrap_inc(b_q, OP_LIMIT);
        end
        pend_nx = 1'b1;
      end
      if (ev.sel) begin
        state_nx = (state == S_A) ? S_B : S_A;
        pend_nx  = 1'b1;
      end
    end
  end

  // Operand registers and the update pulse. pend_q marks the cycle in
  // which the new values first appear; UPD follows one cycle later so it
  // is asserted while the display already sees stable values. CLR always
  // sets pend, so UPD fires even when nothing visibly changed.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      a_q    <= '0;
      b_q    <= '0;
      pend_q <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      a_q    <= a_nx;
      b_q    <= b_nx;
      pend_q <= pend_nx;
      upd_q  <= pend_q;
    end
  end

  assign A   = a_q;
  assign B   = b_q;
  assign SEL = (state == S_B);
  assign UPD = upd_q;

endmodule

// File: tb/tb_zsy_key_entry.sv
// tb/tb_zsy_key_entry.sv - self-checking bench for zsy_key_entry
module tb_zsy_key_entry;

  localparam int DEB = 4;
`ifdef ZSY_HEX_EN
  localparam int LIM = 15;
`else
  localparam int LIM = 9;
`endif

  logic       CP = 1'b0;
  logic       MR = 1'b0;
  logic       KEY_INC = 1'b0;
  logic       KEY_SEL = 1'b0;
  logic       KEY_CLR = 1'b0;
  logic [3:0] A;
  logic [3:0] B;
  logic       SEL;
  logic       UPD;

  always #10 CP = ~CP;

  zsy_key_entry #(.DEB_CYCLES(DEB)) dut (
    .CP      (CP),
    .MR      (MR),
    .KEY_INC (KEY_INC),
    .KEY_SEL (KEY_SEL),
    .KEY_CLR (KEY_CLR),
    .A       (A),
    .B       (B),
    .SEL     (SEL),
    .UPD     (UPD)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
  } exp_t;

  typedef struct {
    logic       inc;
    logic       sel;
    logic       clr;
    int         reps;
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
  } vec_t;

  exp_t       sb[$];
  vec_t       vt[11];
  int         errors = 0;
  int         checks = 0;
  int         upd_seen = 0;
  logic       upd_prev = 1'b0;
  logic [3:0] ma = 4'd0;
  logic [3:0] mb = 4'd0;
  logic       ms = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] bump(input logic [3:0] v);
    return (int'(v) == LIM) ? 4'd0 : v + 4'd1;
  endfunction

  // Reference behaviour of one debounced press event; pushes the outputs
  // expected while UPD is high.
  task automatic model(input logic i, input logic s, input logic c);
    if (c) begin
      ma = 4'd0;
      mb = 4'd0;
      ms = 1'b0;
    end else begin
      if (i) begin
        if (ms) mb = bump(mb);
        else    ma = bump(ma);
      end
      if (s) ms = ~ms;
    end
    sb.push_back('{a: ma, b: mb, s: ms});
  endtask

  task automatic drive(input logic i, input logic s, input logic c);
    @(negedge CP);
    KEY_INC = i;
    KEY_SEL = s;
    KEY_CLR = c;
    model(i, s, c);
    repeat (9) @(negedge CP);
    KEY_INC = 1'b0;
    KEY_SEL = 1'b0;
    KEY_CLR = 1'b0;
    repeat (10) @(negedge CP);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CP);
    chk(name, sb.size(), 0);
  endtask

  // Scoreboard consumer: every UPD pulse must match one expected event.
  always @(negedge CP) begin
    if (MR) begin
      if (UPD) begin
        upd_seen++;
        if (upd_prev) begin
          chk("upd_width", 2, 1);
        end else if (sb.size() == 0) begin
          chk("upd_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("upd_outputs", int'({A, B, SEL}), int'({e.a, e.b, e.s}));
        end
      end
      upd_prev = UPD;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{1'b0, 1'b0, 1'b1, 1, 4'd0, 4'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 2, 4'd2, 4'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1, 4'd2, 4'd0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 9, 4'd2, 4'd9, 1'b1};
`ifdef ZSY_HEX_EN
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1, 4'd2, 4'd10, 1'b0};
`else
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1, 4'd2, 4'd0, 1'b0};
`endif
    vt[5]  = '{1'b1, 1'b0, 1'b1, 1, 4'd0, 4'd0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 3, 4'd3, 4'd0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1, 4'd0, 4'd0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1, 4'd1, 4'd0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1, 4'd1, 4'd1, 1'b1};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1, 4'd1, 4'd1, 1'b0};

    // Reset: MR low 0..25 ns, keys low.
    #15;
    chk("rst_during_A", A, 0);
    chk("rst_during_B", B, 0);
    chk("rst_during_SEL", SEL, 0);
    chk("rst_during_UPD", UPD, 0);
    #10 MR = 1'b1;
    @(negedge CP);
    chk("rst_after_A", A, 0);
    chk("rst_after_B", B, 0);
    chk("rst_after_SEL", SEL, 0);
    chk("rst_after_UPD", UPD, 0);

    // Single clean press: A changes after edge DEB+3, UPD one cycle later.
    @(negedge CP);
    KEY_INC = 1'b1;
    model(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(posedge CP);
      #1;
      if (k == DEB + 2) chk("lat_A_before", A, 0);
      if (k == DEB + 3) begin
        chk("lat_A", A, 1);
        chk("lat_upd_early", UPD, 0);
      end
      if (k == DEB + 4) begin
        chk("lat_upd", UPD, 1);
        chk("lat_B", B, 0);
      end
      if (k == DEB + 5) chk("lat_upd_end", UPD, 0);
    end
    @(negedge CP);
    KEY_INC = 1'b0;
    repeat (12) @(negedge CP);
    drain("lat_drain");
    chk("lat_no_repeat", A, 1);

    // Bouncing key: toggles every 2 cycles, never stable long enough.
    begin
      int a0;
      int u0;
      a0 = A;
      u0 = upd_seen;
      for (int c = 0; c < 20; c++) begin
        @(negedge CP);
        KEY_INC = ((c / 2) % 2) == 0;
      end
      @(negedge CP);
      KEY_INC = 1'b0;
      repeat (12) @(negedge CP);
      chk("bounce_A", A, a0);
      chk("bounce_upd", upd_seen - u0, 0);
    end

    // Table of press combinations with hand-derived final outputs.
    for (int v = 0; v < 11; v++) begin
      for (int r = 0; r < vt[v].reps; r++) drive(vt[v].inc, vt[v].sel, vt[v].clr);
      drain($sformatf("vec%0d_drain", v));
      chk($sformatf("vec%0d_A", v), A, vt[v].a);
      chk($sformatf("vec%0d_B", v), B, vt[v].b);
      chk($sformatf("vec%0d_SEL", v), SEL, vt[v].s);
    end

    // Wrap of the selected operand through the whole range.
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= LIM; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      drain("wrap_drain");
      chk($sformatf("wrap%0d_A", i), A, (i + 1) % (LIM + 1));
    end
    chk("wrap_B", B, 0);

    // Reset in the middle of a debounce with the key still held.
    drive(1'b1, 1'b0, 1'b0);
    drain("mr_pre_drain");
    chk("mr_pre_A", A, 1);
    @(negedge CP);
    KEY_INC = 1'b1;
    repeat (3) @(posedge CP);
    #2 MR = 1'b0;
    ma = 4'd0;
    mb = 4'd0;
    ms = 1'b0;
    sb.delete();
    upd_prev = 1'b0;
    #3;
    chk("mr_mid_A", A, 0);
    chk("mr_mid_B", B, 0);
    chk("mr_mid_SEL", SEL, 0);
    chk("mr_mid_UPD", UPD, 0);
    #10 MR = 1'b1;
    model(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge CP);
      #1;
      if (k == DEB + 2) chk("mr_held_A_before", A, 0);
      if (k == DEB + 3) chk("mr_held_A", A, 1);
    end
    @(negedge CP);
    KEY_INC = 1'b0;
    repeat (12) @(negedge CP);
    drain("mr_held_drain");
    chk("mr_held_once", A, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
